arb_req_mux: RTL and testbench
==============================

// Module: arb_req_mux
// PURPOSE
//   Client-side counterpart to the round-robin arbiter. Buffers one word per client, drives req_o to the arbiter, consumes the one-hot grant, forwards the granted word on a single valid/ready output, and returns ack_o when the word is consumed.
//   Sits between N producer streams and one shared downstream channel.
// PARAMETERS
//   CLIENTS  4   number of requesting clients (>=2)
//   DW       32  data width per client word
// PORTS
//   clk        in   1           single clock; all logic on posedge
//   rst        in   1           synchronous, active-high reset
//   in_valid_i in   CLIENTS     per-client valid
//   in_data_i  in   CLIENTS*DW  per-client data, client i at [i*DW +: DW]
//   in_ready_o out  CLIENTS     per-client ready
//   req_o      out  CLIENTS     request vector to arbiter
//   gnt_i      in   CLIENTS     one-hot grant from arbiter
//   ack_o      out  1           grant consumed, 1-cycle pulse
//   out_valid_o out 1           downstream valid
//   out_data_o out  DW          downstream data
//   out_idx_o  out  $clog2(CLIENTS)  source client of out_data_o
//   out_ready_i in  1           downstream ready
// BEHAVIOUR
//   Reset: all slots empty; req_o=0, in_ready_o='1, ack_o=0, out_valid_o=0, out_data_o=0, out_idx_o=0, FSM=IDLE. Reset mid-transfer drops the word; no ack.
//   Slots: one register per client. in_valid_i[i]&in_ready_o[i] loads slot i; req_o[i]=slot_valid[i] (registered, 1 cycle after accept). in_ready_o[i]=~slot_valid[i] | capture_i.
//   FSM IDLE: if gnt_i!=0, capture granted slot into out regs, clear slot, latch idx -> SEND. out_valid_o rises next cycle. gnt_i=0 -> stay.
//   FSM SEND: out_valid_o=1, data and idx stable. On out_valid_o&out_ready_i, ack_o=1 that same cycle -> IDLE. gnt_i ignored in SEND.
//   Throughput: one word per 2 cycles min (IDLE capture, SEND handshake). out_ready_i held low stalls indefinitely with data stable.
//   Simultaneous load and capture on the same client in one cycle: the captured word leaves and the new word fills the slot; req_o stays high.
//   Grant to an empty slot: ignored, stay IDLE, no ack.
//   Non-one-hot grant: lowest set bit wins.
//   Rising gnt_i in the same cycle as the ack_o pulse is not sampled; earliest next capture is the cycle after ack.
// CONFIGURATION
//   ARB_REQ_MUX_CHECK_EN defined: adds output err_o (1b, sticky until rst). err_o is set when gnt_i is not one-hot in IDLE, or when gnt_i targets an empty slot. The word is still handled per the rules above.
//   Not defined: no err_o port and no check logic.
// STRUCTURE
//   Package arb_pkg: state_e {IDLE, SEND}; localparam IDXW=$clog2(CLIENTS); function onehot_lsb().
//   Sub-module onehot_to_idx: CLIENTS-bit vector -> lowest-set-bit index plus a valid flag.
// TESTING
//   1. Reset: drive rst 2 cycles with inputs toggling -> all outputs at reset values, req_o=0.
//   2. Single: client2 sends 0xA5A5A5A5; gnt_i=4'b0100 -> out_valid_o next cycle, out_idx_o=2; out_ready_i=1 -> ack_o pulse; slot 2 empty.
//   3. Back-to-back: client0 sends 2 words while granted -> in_ready_o[0] stays 1; req_o[0] stays high; both words out in order with 2 acks.
//   4. Stall: out_ready_i=0 for 10 cycles in SEND -> data and idx stable; no ack; gnt_i changes ignored.
//   5. Empty grant: gnt_i=4'b1000 with slot 3 empty -> stay IDLE, no ack. With CHECK_EN, err_o=1 and stays set.
//   6. Bad grant: gnt_i=4'b0110 with both slots full -> client1 forwarded. With CHECK_EN, err_o=1.

Source files
------------

// File: rtl/arb_req_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module : arb_pkg
// Brief  : Shared types, constants and helpers for the arb_req_mux slice.
// Rev    : 1.0  initial release
// ============================================================================
package arb_pkg;

    localparam int DEF_CLIENTS = 4;
    localparam int DEF_DW      = 32;
    localparam int IDXW        = $clog2(DEF_CLIENTS);
    localparam int c_MAXW      = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Isolates the lowest set bit; vectors up to c_MAXW clients.
    function automatic logic [c_MAXW-1:0] onehot_lsb(input logic [c_MAXW-1:0] vec);
        return vec & (~vec + c_MAXW'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_req_mux_if.sv
`default_nettype none
// ============================================================================
// Module : arb_req_mux_if
// Brief  : Client, arbiter and downstream signals of arb_req_mux.
//          err_o exists only when ARB_REQ_MUX_CHECK_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
interface arb_req_mux_if #(
    parameter int CLIENTS = 4,
    parameter int DW      = 32
);
    localparam int c_IDXW = $clog2(CLIENTS);

    logic [CLIENTS-1:0]    in_valid_i;
    logic [CLIENTS*DW-1:0] in_data_i;
    logic [CLIENTS-1:0]    in_ready_o;
    logic [CLIENTS-1:0]    req_o;
    logic [CLIENTS-1:0]    gnt_i;
    logic                  ack_o;
    logic                  out_valid_o;
    logic [DW-1:0]         out_data_o;
    logic [c_IDXW-1:0]     out_idx_o;
    logic                  out_ready_i;
`ifdef ARB_REQ_MUX_CHECK_EN
    logic                  err_o;
`endif

    modport master (
        input  in_valid_i, in_data_i, gnt_i, out_ready_i,
        output in_ready_o, req_o, ack_o, out_valid_o, out_data_o, out_idx_o
`ifdef ARB_REQ_MUX_CHECK_EN
        , output err_o
`endif
    );

    modport slave (
        output in_valid_i, in_data_i, gnt_i, out_ready_i,
        input  in_ready_o, req_o, ack_o, out_valid_o, out_data_o, out_idx_o
`ifdef ARB_REQ_MUX_CHECK_EN
        , input err_o
`endif
    );

endinterface
`default_nettype wire

// File: rtl/arb_req_mux_onehot_to_idx.sv
`default_nettype none
// ============================================================================
// Module : onehot_to_idx
// Brief  : Index of the lowest set bit of a vector plus an any-bit-set flag.
// Rev    : 1.0  initial release
// ============================================================================
module onehot_to_idx
    import arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  wire logic [WIDTH-1:0] i_vec,
    output logic      [IDX_W-1:0] o_idx,
    output logic                  o_valid
);

    logic [WIDTH-1:0] w_lsb;

    assign w_lsb   = WIDTH'(onehot_lsb(c_MAXW'(i_vec)));
    assign o_valid = |i_vec;

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_lsb[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/arb_req_mux.sv
`default_nettype none
// ============================================================================
// Module : arb_req_mux
// Brief  : One-word-per-client buffer feeding a shared valid/ready channel
//          under an external one-hot grant. Optional sticky grant-error flag
//          (err_o) when ARB_REQ_MUX_CHECK_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module arb_req_mux
    import arb_pkg::*;
#(
    parameter int CLIENTS = DEF_CLIENTS,
    parameter int DW      = DEF_DW
) (
    input  wire logic      clk,
    input  wire logic      rst,
    arb_req_mux_if.master  bus
);

    localparam int c_IDXW = $clog2(CLIENTS);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CLIENTS-1:0]  r_slot_valid;
    logic [DW-1:0]       r_slot_data [CLIENTS];
    logic [DW-1:0]       r_out_data;
    logic [c_IDXW-1:0]   r_out_idx;
    logic [c_IDXW-1:0]   w_gnt_idx;
    logic                w_gnt_any;
    logic                w_capture;
    logic                w_ack;
    logic [CLIENTS-1:0]  w_capture_vec;
    logic [CLIENTS-1:0]  w_accept;

    onehot_to_idx #(
        .WIDTH (CLIENTS),
        .IDX_W (c_IDXW)
    ) u_gnt_dec (
        .i_vec   (bus.gnt_i),
        .o_idx   (w_gnt_idx),
        .o_valid (w_gnt_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grants are only sampled in IDLE, so a grant coinciding with ack is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_any && r_slot_valid[w_gnt_idx]) begin
                    w_capture   = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready_i) begin
                    w_ack       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    for (genvar g = 0; g < CLIENTS; g++) begin : g_client
        assign w_capture_vec[g]  = w_capture && (w_gnt_idx == c_IDXW'(g));
        assign bus.in_ready_o[g] = ~r_slot_valid[g] | w_capture_vec[g];
        assign w_accept[g]       = bus.in_valid_i[g] & bus.in_ready_o[g];
    end

    // A load in the capture cycle refills the slot, so the load takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_valid <= '0;
            for (int i = 0; i < CLIENTS; i++) begin
                r_slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CLIENTS; i++) begin
                if (w_accept[i]) begin
                    r_slot_valid[i] <= 1'b1;
                    r_slot_data[i]  <= bus.in_data_i[i*DW +: DW];
                end else if (w_capture_vec[i]) begin
                    r_slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_idx  <= '0;
        end else if (w_capture) begin
            r_out_data <= r_slot_data[w_gnt_idx];
            r_out_idx  <= w_gnt_idx;
        end
    end

    assign bus.req_o       = r_slot_valid;
    assign bus.ack_o       = w_ack;
    assign bus.out_valid_o = (r_state == SEND);
    assign bus.out_data_o  = r_out_data;
    assign bus.out_idx_o   = r_out_idx;

`ifdef ARB_REQ_MUX_CHECK_EN
    logic r_err;
    logic w_err_set;

    assign w_err_set = (r_state == IDLE) && w_gnt_any &&
                       ((onehot_lsb(c_MAXW'(bus.gnt_i)) != c_MAXW'(bus.gnt_i)) ||
                        !r_slot_valid[w_gnt_idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err_o = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arb_req_mux.sv
`default_nettype none
// ============================================================================
// Module : tb_arb_req_mux
// Brief  : Directed and randomized self-checking bench for arb_req_mux.
// Rev    : 1.0  initial release
// ============================================================================
module tb_arb_req_mux;
    import arb_pkg::*;

    localparam int C = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arb_req_mux_if #(.CLIENTS(C), .DW(W)) bus ();
    arb_req_mux #(.CLIENTS(C), .DW(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: what each client slot holds and which word is in flight.
    bit          m_ok = 1'b0;
    bit          m_full [C];
    logic [W-1:0] m_slot [C];
    bit          m_busy = 1'b0;
    logic [W-1:0] m_hold = '0;
    int          m_hold_idx = 0;
    bit          m_err = 1'b0;

    function automatic int lowest(input logic [C-1:0] v);
        for (int i = 0; i < C; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        int k;
        bit cap;
        logic [C-1:0] exp_rdy;
        logic [C-1:0] exp_req;
        k   = lowest(bus.gnt_i);
        cap = !m_busy && (k >= 0) && m_full[k];
        for (int i = 0; i < C; i++) begin
            exp_rdy[i] = !m_full[i] || (cap && k == i);
            exp_req[i] = m_full[i];
        end
        if (m_ok) begin
            check("in_ready", 64'(bus.in_ready_o), 64'(exp_rdy));
            check("req", 64'(bus.req_o), 64'(exp_req));
            check("ack", 64'(bus.ack_o), 64'(m_busy && bus.out_ready_i));
            check("out_valid", 64'(bus.out_valid_o), 64'(m_busy));
            check("out_data", 64'(bus.out_data_o), 64'(m_hold));
            check("out_idx", 64'(bus.out_idx_o), 64'(m_hold_idx));
`ifdef ARB_REQ_MUX_CHECK_EN
            check("err", 64'(bus.err_o), 64'(m_err));
`endif
        end
        // Advance the model to the state the next rising edge produces.
        if (rst) begin
            m_ok = 1'b1;
            m_busy = 1'b0; m_hold = '0; m_hold_idx = 0; m_err = 1'b0;
            for (int i = 0; i < C; i++) begin m_full[i] = 1'b0; m_slot[i] = '0; end
        end else if (m_ok) begin
            if (!m_busy && k >= 0 && ($countones(bus.gnt_i) > 1 || !m_full[k])) m_err = 1'b1;
            if (m_busy && bus.out_ready_i) m_busy = 1'b0;
            if (cap) begin m_busy = 1'b1; m_hold = m_slot[k]; m_hold_idx = k; end
            for (int i = 0; i < C; i++) begin
                if (bus.in_valid_i[i] && exp_rdy[i]) begin
                    m_full[i] = 1'b1;
                    m_slot[i] = bus.in_data_i[i*W +: W];
                end else if (cap && k == i) begin
                    m_full[i] = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #2;
    endtask

    task automatic rand_inputs();
        bus.in_valid_i = C'($urandom);
        for (int i = 0; i < C; i++) bus.in_data_i[i*W +: W] = $urandom;
        case ($urandom_range(0, 3))
            0: bus.gnt_i = '0;
            1: bus.gnt_i = C'(1) << $urandom_range(0, C-1);
            2: bus.gnt_i = C'($urandom);
            default: bus.gnt_i = bus.req_o & (~bus.req_o + C'(1));
        endcase
        bus.out_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle_inputs();
        bus.in_valid_i = '0; bus.gnt_i = '0; bus.out_ready_i = 1'b0;
    endtask

    initial begin
        bus.in_data_i = '0;
        rand_inputs();
        // Reset held for two edges while inputs toggle
        step(); rand_inputs();
        step(); rst = 1'b0; idle_inputs();
        sample();
        check("rst_req", 64'(bus.req_o), 64'h0);
        check("rst_in_ready", 64'(bus.in_ready_o), 64'hF);
        check("rst_ack", 64'(bus.ack_o), 64'h0);
        check("rst_out_valid", 64'(bus.out_valid_o), 64'h0);
        check("rst_out_data", 64'(bus.out_data_o), 64'h0);
        check("rst_out_idx", 64'(bus.out_idx_o), 64'h0);

        // Single word from client 2
        step(); bus.in_valid_i = 4'b0100; bus.in_data_i[2*W +: W] = 32'hA5A5A5A5;
        step(); bus.in_valid_i = '0; bus.gnt_i = 4'b0100;
        sample(); check("single_req", 64'(bus.req_o), 64'h4);
        check("single_valid_pre", 64'(bus.out_valid_o), 64'h0);
        step(); bus.gnt_i = '0; bus.out_ready_i = 1'b1;
        sample();
        check("single_valid", 64'(bus.out_valid_o), 64'h1);
        check("single_idx", 64'(bus.out_idx_o), 64'h2);
        check("single_data", 64'(bus.out_data_o), 64'hA5A5A5A5);
        check("single_ack", 64'(bus.ack_o), 64'h1);
        check("single_slot_empty", 64'(bus.req_o), 64'h0);
        step(); idle_inputs();
        sample(); check("single_ack_done", 64'(bus.ack_o), 64'h0);
`ifdef ARB_REQ_MUX_CHECK_EN
        check("err_clean", 64'(bus.err_o), 64'h0);
`endif

        // Grant to an empty slot
        step(); bus.gnt_i = 4'b1000;
        sample(); check("empty_ack", 64'(bus.ack_o), 64'h0);
        step(); bus.gnt_i = '0;
        sample(); check("empty_idle", 64'(bus.out_valid_o), 64'h0);
`ifdef ARB_REQ_MUX_CHECK_EN
        check("empty_err", 64'(bus.err_o), 64'h1);
`endif

        // Back-to-back on client 0: load and capture in the same cycle
        step(); bus.in_valid_i = 4'b0001; bus.in_data_i[W-1:0] = 32'h0000C0DE;
        step(); bus.in_data_i[W-1:0] = 32'h1111C0DE; bus.gnt_i = 4'b0001;
        sample(); check("b2b_ready", 64'(bus.in_ready_o), 64'hF);
        step(); bus.in_valid_i = '0; bus.gnt_i = '0; bus.out_ready_i = 1'b1;
        sample();
        check("b2b_data0", 64'(bus.out_data_o), 64'h0000C0DE);
        check("b2b_ack0", 64'(bus.ack_o), 64'h1);
        check("b2b_req", 64'(bus.req_o), 64'h1);
        step(); bus.gnt_i = 4'b0001; bus.out_ready_i = 1'b0;
        step(); bus.gnt_i = '0; bus.out_ready_i = 1'b1;
        sample();
        check("b2b_data1", 64'(bus.out_data_o), 64'h1111C0DE);
        check("b2b_ack1", 64'(bus.ack_o), 64'h1);
        step(); idle_inputs();

        // Non-one-hot grant, then a long stall with the grant wiggling
        step(); bus.in_valid_i = 4'b0110;
        bus.in_data_i[W +: W] = 32'h11111111; bus.in_data_i[2*W +: W] = 32'h22222222;
        step(); bus.in_valid_i = '0; bus.gnt_i = 4'b0110;
        sample(); check("bad_req", 64'(bus.req_o), 64'h6);
        step(); bus.gnt_i = C'($urandom);
        sample();
        check("bad_idx", 64'(bus.out_idx_o), 64'h1);
        check("bad_data", 64'(bus.out_data_o), 64'h11111111);
        check("bad_req_left", 64'(bus.req_o), 64'h4);
`ifdef ARB_REQ_MUX_CHECK_EN
        check("bad_err", 64'(bus.err_o), 64'h1);
`endif
        for (int s = 0; s < 10; s++) begin
            step(); bus.gnt_i = C'($urandom);
            sample();
            check("stall_ack", 64'(bus.ack_o), 64'h0);
            check("stall_data", 64'(bus.out_data_o), 64'h11111111);
            check("stall_idx", 64'(bus.out_idx_o), 64'h1);
        end
        step(); bus.gnt_i = '0; bus.out_ready_i = 1'b1;
        sample(); check("stall_release", 64'(bus.ack_o), 64'h1);
        step(); bus.gnt_i = 4'b0100; bus.out_ready_i = 1'b0;
        step(); bus.gnt_i = '0; bus.out_ready_i = 1'b1;
        sample();
        check("bad_second_idx", 64'(bus.out_idx_o), 64'h2);
        check("bad_second_data", 64'(bus.out_data_o), 64'h22222222);
        step(); idle_inputs();

        // Randomized traffic with occasional mid-transfer reset
        for (int n = 0; n < 4000; n++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            rand_inputs();
        end
        step(); rst = 1'b0; idle_inputs();
        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
